ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave_if.sv | 46 ++++
 rtl/ahb_sram_slave.sv | 214 +++++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
//
// AHB-Lite bus bundle between one master-side driver and the SRAM responder.
//
// Signals:
//   HSEL       slave select from the address decoder
//   HADDR      address-phase address (32 bits)
//   HTRANS     transfer type; bit 1 set = NONSEQ/SEQ
//   HWRITE     1 = write
//   HSIZE      0 byte, 1 halfword, 2 word; >2 illegal
//   HWDATA     write data, valid in the data phase
//   HREADY     bus-level ready (previous transfer completes)
//   HREADYOUT  responder ready
//   HRESP      0 OKAY, 1 ERROR
//   HRDATA     read data
//   dbg_state  responder FSM state (0 IDLE, 1 WAIT, 2 ERR1, 3 ERR2)
//
// Handshake: a transfer is accepted on a rising HCLK edge where
// HSEL & HTRANS[1] & HREADY are all high; its data phase then runs until the
// first edge at which HREADYOUT is high, and that edge ends it. HRESP is only
// meaningful while a data phase is pending.
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [1:0]  dbg_state;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA, dbg_state
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA, dbg_state
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite responder in front of an inferred word-wide single-port SRAM.
// Supports byte / halfword / word transfers, a fixed number of wait states
// per OKAY data phase, byte-lane writes, read-after-write bypass and the
// two-cycle ERROR response for misaligned or oversized accesses.
//
// Parameters:
//   AW           word-address width; depth is 2**AW words. HADDR[AW+1:2]
//                indexes the array, higher address bits alias.
//   WAIT_STATES  wait cycles inserted into every OKAY data phase (0..7)
//
// Ports:
//   HCLK    bus clock, rising edge
//   HRESET  synchronous active-high reset
//   bus     AHB-Lite slave modport (see ahb_sram_slave_if)
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahb_sram_slave_if.slave bus
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [2:0] wcnt, wcnt_nxt;
  logic       ready_int, resp_int;

  // Data-phase context captured at the accept edge.
  logic          last_valid;
  logic          last_write;
  logic          last_illegal;
  logic [2:0]    last_size;
  logic [AW+1:0] last_addr;

  logic [31:0] rdata;
  logic [31:0] rd_word;
  logic [31:0] mem [0:(1<<AW)-1];

  logic          accept;
  logic          acc_illegal;
  logic          acc_read;
  logic          commit_we;
  logic          phase_done;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;

  // Byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] lane_en(input logic [2:0] size,
                                         input logic [1:0] lo);
    case (size)
      3'd0:    lane_en = 4'b0001 << lo;
      3'd1:    lane_en = lo[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  assign acc_illegal = (bus.HSIZE > 3'd2)
                     | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                     | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));

  // New transfers are only taken when no data phase is stalling (IDLE) or
  // in the completing cycle of an ERROR response (ERR2).
  assign accept   = ((state == IDLE) | (state == ERR2))
                  & bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign acc_read = accept & ~bus.HWRITE & ~acc_illegal;

  assign rd_idx = bus.HADDR[AW+1:2];
  assign wr_idx = last_addr[AW+1:2];
  assign wr_be  = lane_en(last_size, last_addr[1:0]);

  // A legal write lands on the edge that ends its data phase; in IDLE the
  // responder is driving HREADYOUT high, so that edge is this one.
  assign commit_we  = last_valid & last_write & ~last_illegal & (state == IDLE);
  assign phase_done = last_valid & ready_int;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
      wcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and response outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    ready_int = 1'b1;
    resp_int  = 1'b0;
    case (state)
      IDLE, ERR2: begin
        ready_int = 1'b1;
        resp_int  = (state == ERR2);
        state_nxt = IDLE;
        if (accept) begin
          if (acc_illegal) begin
            state_nxt = ERR1;
          end else if (WS != 3'd0) begin
            state_nxt = WAIT;
            wcnt_nxt  = WS;
          end
        end
      end
      WAIT: begin
        ready_int = 1'b0;
        wcnt_nxt  = wcnt - 3'd1;
        // The cycle after wcnt reaches 1 is the zero-wait completing cycle.
        if (wcnt <= 3'd1) begin
          state_nxt = IDLE;
        end
      end
      ERR1: begin
        ready_int = 1'b0;
        resp_int  = 1'b1;
        state_nxt = ERR2;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Data-phase context
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_valid   <= 1'b0;
      last_write   <= 1'b0;
      last_illegal <= 1'b0;
      last_size    <= 3'd0;
      last_addr    <= '0;
    end else if (accept) begin
      last_valid   <= 1'b1;
      last_write   <= bus.HWRITE;
      last_illegal <= acc_illegal;
      last_size    <= bus.HSIZE;
      last_addr    <= bus.HADDR[AW+1:0];
    end else if (phase_done) begin
      last_valid   <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Memory array. Contents are intentionally not reset; a write still
  // pending when reset arrives is dropped.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit_we) begin
      if (wr_be[0]) mem[wr_idx][7:0]   <= bus.HWDATA[7:0];
      if (wr_be[1]) mem[wr_idx][15:8]  <= bus.HWDATA[15:8];
      if (wr_be[2]) mem[wr_idx][23:16] <= bus.HWDATA[23:16];
      if (wr_be[3]) mem[wr_idx][31:24] <= bus.HWDATA[31:24];
    end
  end

  // Read word with bypass: when the same edge commits a write to the word
  // being read, the freshly written lanes replace the stale array bytes.
  always_comb begin
    rd_word = mem[rd_idx];
    if (commit_we && (rd_idx == wr_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Sampled on the accept edge so a zero-wait read has data next cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rdata <= 32'd0;
    end else if (acc_read) begin
      rdata <= rd_word;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.HREADYOUT = ready_int;
  assign bus.HRESP     = resp_int;
  assign bus.HRDATA    = (last_valid & ~last_write & ~last_illegal) ? rdata : 32'd0;
  assign bus.dbg_state = state;

  // Address bits above the array and HTRANS[0] do not affect behaviour.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Three responders (0, 3 and 5 wait states) share one clock, reset and
// master-side signal set; HSEL is steered to the responder selected by 'act'.
// A word-array reference model tracks committed writes; read expectations
// are pushed to exp_q when the address phase is driven and popped when the
// data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  // ---------------------------------------------------------------- clock/reset
  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  // ---------------------------------------------------------------- bus drive
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  int          act;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();
  ahb_sram_slave_if bus2 ();

  assign bus0.HSEL   = hsel & (act == 0);
  assign bus0.HADDR  = haddr;
  assign bus0.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;
  assign bus0.HSIZE  = hsize;
  assign bus0.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus1.HSEL   = hsel & (act == 1);
  assign bus1.HADDR  = haddr;
  assign bus1.HTRANS = htrans;
  assign bus1.HWRITE = hwrite;
  assign bus1.HSIZE  = hsize;
  assign bus1.HWDATA = hwdata;
  assign bus1.HREADY = bus1.HREADYOUT;

  assign bus2.HSEL   = hsel & (act == 2);
  assign bus2.HADDR  = haddr;
  assign bus2.HTRANS = htrans;
  assign bus2.HWRITE = hwrite;
  assign bus2.HSIZE  = hsize;
  assign bus2.HWDATA = hwdata;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb_sram_slave #(.AW(10), .WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus0.slave));
  ahb_sram_slave #(.AW(10), .WAIT_STATES(3)) dut1 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus1.slave));
  ahb_sram_slave #(.AW(10), .WAIT_STATES(5)) dut2 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2.slave));

  logic        cur_ready;
  logic        cur_resp;
  logic [31:0] cur_rdata;
  logic [1:0]  cur_state;

  always_comb begin
    cur_ready = bus0.HREADYOUT;
    cur_resp  = bus0.HRESP;
    cur_rdata = bus0.HRDATA;
    cur_state = bus0.dbg_state;
    case (act)
      1: begin
        cur_ready = bus1.HREADYOUT;
        cur_resp  = bus1.HRESP;
        cur_rdata = bus1.HRDATA;
        cur_state = bus1.dbg_state;
      end
      2: begin
        cur_ready = bus2.HREADYOUT;
        cur_resp  = bus2.HRESP;
        cur_rdata = bus2.HRDATA;
        cur_state = bus2.dbg_state;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] model [0:2][0:1023];
  int          checks = 0;
  int          errors = 0;

  bit          pend_w;
  logic [31:0] pend_a;
  logic [2:0]  pend_sz;
  logic [31:0] pend_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic [3:0]  be;
    logic [31:0] w;
    case (sz)
      3'd0:    be = 4'b0001 << a[1:0];
      3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    w = model[act][a[11:2]];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    end
    model[act][a[11:2]] = w;
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  // Drive an address phase; it is accepted at the next edge.
  task automatic start(input bit w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd);
    hsel    = 1'b1;
    htrans  = 2'b10;
    hwrite  = w;
    haddr   = a;
    hsize   = sz;
    pend_w  = w;
    pend_a  = a;
    pend_sz = sz;
    pend_wd = wd;
    if (!w && is_legal(a, sz)) exp_q.push_back(model[act][a[11:2]]);
  endtask

  // Called one step after the accept edge. Stalls through wait cycles with
  // junk write data, then handles the completing cycle. Returns without
  // advancing the clock so the caller may pipeline the next address phase.
  task automatic finish_okay(input int exp_waits);
    int          waits;
    logic [31:0] want;
    waits = 0;
    idle_bus();
    while (cur_ready !== 1'b1 && waits < 20) begin
      chk("wait_resp", 32'(cur_resp), 32'd0);
      hwdata = $urandom;
      tick();
      waits++;
    end
    chk("wait_count", 32'(waits), 32'(exp_waits));
    chk("okay_resp", 32'(cur_resp), 32'd0);
    if (pend_w) begin
      hwdata = pend_wd;
      model_write(pend_a, pend_sz, pend_wd);
    end else begin
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      chk("rdata", cur_rdata, want);
    end
  endtask

  // Called one step after the accept edge of an illegal transfer; returns in
  // the ERR2 cycle so the caller may start a new transfer there.
  task automatic err_phase;
    idle_bus();
    chk("err1_ready", 32'(cur_ready), 32'd0);
    chk("err1_resp", 32'(cur_resp), 32'd1);
    hwdata = $urandom;
    tick();
    chk("err2_ready", 32'(cur_ready), 32'd1);
    chk("err2_resp", 32'(cur_resp), 32'd1);
    chk("err2_rdata", cur_rdata, 32'd0);
  endtask

  // Complete, non-pipelined transfer followed by an idle-cycle check.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input int exp_waits);
    start(w, a, sz, wd);
    tick();
    finish_okay(exp_waits);
    tick();
    chk("idle_ready", 32'(cur_ready), 32'd1);
    chk("idle_rdata", cur_rdata, 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] ra;
    logic [2:0]  rs;
    bit          rw;

    act    = 0;
    idle_bus();
    haddr  = 32'd0;
    hsize  = 3'd2;
    hwdata = 32'd0;
    HRESET = 1'b1;
    repeat (3) tick();

    // Reset state of every responder.
    chk("rst_ready0", 32'(bus0.HREADYOUT), 32'd1);
    chk("rst_resp0", 32'(bus0.HRESP), 32'd0);
    chk("rst_rdata0", bus0.HRDATA, 32'd0);
    chk("rst_state0", 32'(bus0.dbg_state), 32'd0);
    chk("rst_ready1", 32'(bus1.HREADYOUT), 32'd1);
    chk("rst_rdata1", bus1.HRDATA, 32'd0);
    chk("rst_ready2", 32'(bus2.HREADYOUT), 32'd1);
    chk("rst_rdata2", bus2.HRDATA, 32'd0);
    HRESET = 1'b0;
    tick();

    // Zero-wait pipelined write then read of the same word (bypass path).
    act = 0;
    start(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    tick();
    finish_okay(0);
    start(1'b0, 32'h10, 3'd2, 32'd0);
    tick();
    chk("bypass_rdata", cur_rdata, 32'hDEADBEEF);
    finish_okay(0);
    tick();
    chk("bypass_idle", cur_rdata, 32'd0);

    // Byte lanes.
    xfer(1'b1, 32'h20, 3'd2, 32'h00000000, 0);
    xfer(1'b1, 32'h21, 3'd0, 32'h0000AB00, 0);
    xfer(1'b1, 32'h22, 3'd1, 32'hCDEF0000, 0);
    start(1'b0, 32'h20, 3'd2, 32'd0);
    tick();
    chk("lanes_const", cur_rdata, 32'hCDEFAB00);
    finish_okay(0);
    tick();

    // Back-to-back zero-wait traffic: fill a region, then random mix.
    for (int i = 0; i < 16; i++) begin
      start(1'b1, 32'h40 + 32'(4 * i), 3'd2, $urandom);
      tick();
      finish_okay(0);
    end
    for (int i = 0; i < 24; i++) begin
      rw = 1'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 2));
      ra = 32'h40 + 32'($urandom_range(0, 63));
      if (rs == 3'd1) ra[0] = 1'b0;
      if (rs == 3'd2) ra[1:0] = 2'b00;
      start(rw, ra, rs, $urandom);
      tick();
      finish_okay(0);
    end
    tick();

    // Three wait states: reads, and writes with HWDATA churning in waits.
    act = 1;
    xfer(1'b1, 32'h10, 3'd2, 32'hA5A50F0F, 3);
    xfer(1'b0, 32'h10, 3'd2, 32'd0, 3);
    xfer(1'b1, 32'h11, 3'd0, 32'h00007700, 3);
    xfer(1'b1, 32'h12, 3'd1, 32'h12340000, 3);
    xfer(1'b0, 32'h10, 3'd2, 32'd0, 3);

    // Illegal accesses leave memory untouched.
    act = 0;
    xfer(1'b1, 32'h10, 3'd2, 32'h11223344, 0);
    xfer(1'b1, 32'h00, 3'd2, 32'h99887766, 0);
    start(1'b1, 32'h12, 3'd2, 32'hFFFFFFFF);
    tick();
    err_phase();
    tick();
    chk("err_done_resp", 32'(cur_resp), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'd0, 0);
    start(1'b1, 32'h01, 3'd1, 32'hFFFFFFFF);
    tick();
    err_phase();
    tick();
    xfer(1'b0, 32'h00, 3'd2, 32'd0, 0);
    start(1'b1, 32'h10, 3'd3, 32'hFFFFFFFF);
    tick();
    err_phase();
    start(1'b0, 32'h10, 3'd2, 32'd0);   // accepted in ERR2
    tick();
    finish_okay(0);
    tick();
    chk("after_err_ready", 32'(cur_ready), 32'd1);

    // Non-accepted cycles with HWRITE high have no effect.
    hwdata = 32'hFFFFFFFF;
    hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    tick();
    chk("nosel_ready", 32'(cur_ready), 32'd1);
    chk("nosel_resp", 32'(cur_resp), 32'd0);
    hsel = 1'b1; htrans = 2'b00;
    tick();
    chk("idle_state", 32'(cur_state), 32'd0);
    htrans = 2'b01;
    tick();
    chk("busy_ready", 32'(cur_ready), 32'd1);
    idle_bus();
    tick();
    xfer(1'b0, 32'h10, 3'd2, 32'd0, 0);

    // Aliasing: bits above the word index are ignored.
    xfer(1'b1, 32'h1010, 3'd2, 32'h0BADF00D, 0);
    start(1'b0, 32'h0010, 3'd2, 32'd0);
    tick();
    chk("alias_const", cur_rdata, 32'h0BADF00D);
    finish_okay(0);
    tick();

    // Reset during the second wait cycle aborts the write.
    act = 2;
    xfer(1'b1, 32'h30, 3'd2, 32'h55AA55AA, 5);
    start(1'b1, 32'h30, 3'd2, 32'h12345678);
    tick();
    idle_bus();
    hwdata = 32'h12345678;
    chk("mid_wait1", 32'(cur_ready), 32'd0);
    tick();
    chk("mid_wait2", 32'(cur_ready), 32'd0);
    HRESET = 1'b1;
    tick();
    chk("abort_ready", 32'(cur_ready), 32'd1);
    chk("abort_resp", 32'(cur_resp), 32'd0);
    chk("abort_rdata", cur_rdata, 32'd0);
    chk("abort_state", 32'(cur_state), 32'd0);
    HRESET = 1'b0;
    tick();
    start(1'b0, 32'h30, 3'd2, 32'd0);
    tick();
    finish_okay(5);
    chk("abort_mem_const", cur_rdata, 32'h55AA55AA);
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
